// File: rtl/mips_pipe_skid_reg_if.sv
// Handshaked payload bus between two MIPS pipeline stages (upstream In*, downstream Out*).
// The slave modport is the pipeline register's view; master is the surrounding stages' view.
interface mips_pipe_skid_reg_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned PC_WIDTH   = 32
);
  logic                  InValid;
  logic                  InReady;
  logic [DATA_WIDTH-1:0] InData;
  logic [PC_WIDTH-1:0]   InPc;
  logic                  InHit;
  logic                  OutValid;
  logic                  OutReady;
  logic [DATA_WIDTH-1:0] OutData;
  logic [PC_WIDTH-1:0]   OutPc;
  logic                  OutHit;

  modport slave (
    input  InValid, InData, InPc, InHit, OutReady,
    output InReady, OutValid, OutData, OutPc, OutHit
  );

  modport master (
    output InValid, InData, InPc, InHit, OutReady,
    input  InReady, OutValid, OutData, OutPc, OutHit
  );
endinterface

// File: rtl/mips_pipe_skid_reg.sv
// Two-entry skid pipeline register with valid/ready flow control, flush to NOP bubble
// and a saturating back-pressure cycle counter.
module mips_pipe_skid_reg #(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned PC_WIDTH        = 32,
  parameter int unsigned STALL_CNT_WIDTH = 16
) (
  input  logic                       ClockPulse,
  input  logic                       Reset,
  input  logic                       Flush,
  mips_pipe_skid_reg_if.slave        bus,
  output logic [1:0]                 Occupancy,
  output logic [STALL_CNT_WIDTH-1:0] StallCount
);

  localparam int unsigned PayloadWidth = DATA_WIDTH + PC_WIDTH + 1;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e                     state_q;
  logic [PayloadWidth-1:0]    main_q;
  logic [PayloadWidth-1:0]    skid_q;
  logic [PayloadWidth-1:0]    in_payload;
  logic                       out_valid_q;
  logic                       in_ready_q;
  logic [STALL_CNT_WIDTH-1:0] stall_q;
  logic                       in_fire;
  logic                       out_fire;

  assign in_payload = {bus.InData, bus.InPc, bus.InHit};
  assign in_fire    = bus.InValid & in_ready_q;
  assign out_fire   = out_valid_q & bus.OutReady;

  always_ff @(posedge ClockPulse) begin
    if (Reset) begin
      state_q     <= StEmpty;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      stall_q     <= '0;
    end else begin
      // Counts independently of Flush so squashes do not hide back-pressure history.
      if (out_valid_q && !bus.OutReady && (stall_q != '1)) begin
        stall_q <= stall_q + STALL_CNT_WIDTH'(1);
      end
      if (Flush) begin
        state_q     <= StEmpty;
        main_q      <= '0;
        skid_q      <= '0;
        out_valid_q <= 1'b0;
        in_ready_q  <= 1'b1;
      end else begin
        unique case (state_q)
          StEmpty: begin
            if (in_fire) begin
              state_q     <= StOne;
              main_q      <= in_payload;
              out_valid_q <= 1'b1;
            end
          end
          StOne: begin
            if (in_fire && out_fire) begin
              main_q <= in_payload;
            end else if (in_fire) begin
              state_q    <= StFull;
              skid_q     <= in_payload;
              in_ready_q <= 1'b0;
            end else if (out_fire) begin
              state_q     <= StEmpty;
              out_valid_q <= 1'b0;
            end
          end
          StFull: begin
            if (out_fire) begin
              state_q    <= StOne;
              main_q     <= skid_q;
              in_ready_q <= 1'b1;
            end
          end
          default: begin
            state_q     <= StEmpty;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.OutValid = out_valid_q;
  assign bus.InReady  = in_ready_q;
  // Stale main contents are masked so an idle stage always sees a NOP bubble.
  assign {bus.OutData, bus.OutPc, bus.OutHit} = out_valid_q ? main_q : '0;
  assign StallCount = stall_q;

  always_comb begin
    Occupancy = 2'd0;
    unique case (state_q)
      StEmpty: Occupancy = 2'd0;
      StOne:   Occupancy = 2'd1;
      StFull:  Occupancy = 2'd2;
      default: Occupancy = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_mips_pipe_skid_reg.sv
// Scoreboard bench: accepted payloads are queued at acceptance and popped by the monitor
// whenever the DUT hands one downstream; a small counter model tracks StallCount.
module tb_mips_pipe_skid_reg;

  localparam int unsigned DW = 64;
  localparam int unsigned PW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned Smax = (1 << SW) - 1;

  logic          clk;
  logic          Reset;
  logic          Flush;
  logic [1:0]    Occupancy;
  logic [SW-1:0] StallCount;

  mips_pipe_skid_reg_if #(.DATA_WIDTH(DW), .PC_WIDTH(PW)) bus ();

  mips_pipe_skid_reg #(
    .DATA_WIDTH     (DW),
    .PC_WIDTH       (PW),
    .STALL_CNT_WIDTH(SW)
  ) dut (
    .ClockPulse(clk),
    .Reset     (Reset),
    .Flush     (Flush),
    .bus       (bus),
    .Occupancy (Occupancy),
    .StallCount(StallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW+PW:0] exp_q[$];
  int             exp_stall = 0;
  bit             chk_en = 0;
  bit             acc_s = 0;
  bit             stall_s = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor/model: update on the rising edge, compare mid-cycle on the falling edge.
  initial begin
    forever begin
      @(posedge clk);
      if (Reset) begin
        exp_q.delete();
        exp_stall = 0;
        chk_en = 1;
      end else if (chk_en) begin
        if (stall_s && exp_stall < Smax) exp_stall++;
        if (Flush) exp_q.delete();
        else if (acc_s) exp_q.push_back({bus.InData, bus.InPc, bus.InHit});
      end
      @(negedge clk);
      if (chk_en) begin
        bit m_valid;
        bit m_ready;
        m_valid = exp_q.size() > 0;
        m_ready = exp_q.size() < 2;
        check("OutValid", 128'(bus.OutValid), 128'(m_valid));
        check("InReady", 128'(bus.InReady), 128'(m_ready));
        check("Occupancy", 128'(Occupancy), 128'(exp_q.size()));
        check("StallCount", 128'(StallCount), 128'(exp_stall));
        if (m_valid) begin
          check("OutPayload", 128'({bus.OutData, bus.OutPc, bus.OutHit}), 128'(exp_q[0]));
          if (bus.OutReady) void'(exp_q.pop_front());
        end else begin
          check("BubblePayload", 128'({bus.OutData, bus.OutPc, bus.OutHit}), 128'(0));
        end
        acc_s   = bus.InValid && m_ready;
        stall_s = m_valid && !bus.OutReady;
      end
    end
  end

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [PW-1:0] pc,
                       input logic h, input logic rdy, input logic fl, input logic rs);
    bus.InValid  = v;
    bus.InData   = d;
    bus.InPc     = pc;
    bus.InHit    = h;
    bus.OutReady = rdy;
    Flush        = fl;
    Reset        = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, '0, '0, 1'b0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Single transfer
    drive(1'b1, 64'h0000_0000_1234_5678, 32'h0040_0004, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Back-to-back stream
    for (int i = 1; i <= 8; i++) drive(1'b1, 64'(i), 32'(i * 4), i[0], 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Fill skid under back-pressure, then drain
    drive(1'b1, 64'hA, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 64'hB, 32'h104, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Flush while full with a same-cycle input
    drive(1'b1, 64'hA1, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 64'hB1, 32'h204, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 64'hC1, 32'h208, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Saturate the stall counter
    drive(1'b1, 64'hD1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) idle(1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b1);

    // Reset while full with input pending, then first post-reset payload
    drive(1'b1, 64'hE1, 32'h400, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 64'hE2, 32'h404, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 64'hE3, 32'h408, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 64'hF1, 32'h500, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Randomised traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, $urandom, 1'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0),
            1'($urandom_range(0, 299) == 0));
    end
    idle(1'b1);
    idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
